// File: rtl/mtrx_mul_pkg.sv
// Shared types and helpers for the matrix-multiply datapath stages.
package mtrx_mul_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

  // Index width for a counter over n positions; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_index_cnt.sv
// Nested x/y index counter: y is the inner index, x the outer; flags the final position.
module drain_index_cnt
  import mtrx_mul_pkg::*;
#(
  parameter int unsigned X = 64,
  parameter int unsigned Y = 8568
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [cnt_w(X)-1:0] x_o,
  output logic [cnt_w(Y)-1:0] y_o,
  output logic                last_o
);

  localparam int unsigned XW = cnt_w(X);
  localparam int unsigned YW = cnt_w(Y);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end = (x_q == XW'(X - 1));
  assign y_end = (y_q == YW'(Y - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (inc_i) begin
      if (y_end) begin
        y_d = '0;
        x_d = x_end ? '0 : x_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_end && y_end;

endmodule

// File: rtl/result_drain.sv
// Captures a full result frame and streams it out element by element (y inner, x outer).
module result_drain
  import mtrx_mul_pkg::*;
#(
  parameter int unsigned M    = 5,
  parameter int unsigned X    = 64,
  parameter int unsigned Y    = 8568,
  parameter int unsigned RELU = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [X*Y*M-1:0]    Data,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [M-1:0]        out_data,
  output logic [cnt_w(X)-1:0] out_x,
  output logic [cnt_w(Y)-1:0] out_y,
  output logic                out_last,
  output logic                frame_done
);

  localparam int unsigned FW = cnt_w(X * Y * M);

  drain_state_e      state_q, state_d;
  logic              done_q, done_d;
  logic [X*Y*M-1:0]  frame_q;
  logic              capture, fire, cnt_clr, last;
  logic [FW-1:0]     base;
  logic [M-1:0]      elem;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    capture   = 1'b0;
    fire      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture = 1'b1;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) begin
          fire = 1'b1;
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over capture and transfer, and cancels a pending frame_done.
    if (clr) begin
      state_d = IDLE;
      done_d  = 1'b0;
      capture = 1'b0;
      fire    = 1'b0;
    end
    cnt_clr = clr | capture | (fire & last);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) frame_q <= Data;
  end

  drain_index_cnt #(
    .X (X),
    .Y (Y)
  ) u_idx (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (cnt_clr),
    .inc_i  (fire),
    .x_o    (out_x),
    .y_o    (out_y),
    .last_o (last)
  );

  always_comb begin
    base     = (FW'(out_x) * FW'(Y) + FW'(out_y)) * FW'(M);
    elem     = frame_q[base +: M];
    out_data = ((RELU != 0) && elem[M-1]) ? '0 : elem;
  end

  assign out_last   = last;
  assign frame_done = done_q;

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter M, default 5: width of one result element in bits.
REQ-002 Parameter X, default 64: number of filters, the outer stream index.
REQ-003 Parameter Y, default 8568: number of image positions, the inner stream index.
REQ-004 Parameter RELU, default 0: 1 clamps negative elements (two's complement) to zero on output.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 clr  input  1  synchronous abort; returns the block to IDLE.
REQ-008 in_valid  input  1  Data from the systolic array is complete and stable.
REQ-009 Data  input  X*Y*M  flat result bus; element (x,y) occupies Data[(x*Y+y)*M +: M].
REQ-010 in_ready  output  1  block can capture a new Data frame.
REQ-011 out_valid  output  1  out_data, out_x, out_y and out_last are valid.
REQ-012 out_ready  input  1  downstream accepts the current beat.
REQ-013 out_data  output  M  current element, after optional ReLU.
REQ-014 out_x  output  clog2(X), minimum 1  filter index of the current beat.
REQ-015 out_y  output  clog2(Y), minimum 1  image index of the current beat.
REQ-016 out_last  output  1  high on the beat where x=X-1 and y=Y-1.
REQ-017 frame_done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-018 The FSM SHALL have two states: IDLE and STREAM.
REQ-019 In IDLE: in_ready=1 and out_valid=0.
REQ-020 In IDLE, in_valid=1 SHALL capture the whole Data bus into an internal frame register, clear both counters to 0 and enter STREAM on the next edge.
REQ-021 out_valid SHALL rise in the first cycle after capture; capture-to-first-beat latency is 1 cycle.
REQ-022 In STREAM: in_ready=0; in_valid and changes on Data SHALL be ignored.
REQ-023 A beat transfers only when out_valid=1 and out_ready=1.
REQ-024 While out_ready=0, out_data, out_x, out_y and out_last SHALL hold stable.
REQ-025 Stream order SHALL be y inner and x outer: (0,0),(0,1)..(0,Y-1),(1,0)..(X-1,Y-1).
REQ-026 On each transfer y increments; at y=Y-1, y wraps to 0 and x increments.
REQ-027 On the transfer with out_last=1, the FSM SHALL enter IDLE, clear both counters and assert frame_done for exactly the next cycle.
REQ-028 After the last beat there is exactly one IDLE cycle (in_ready=1) before another capture can take effect.
REQ-029 If RELU=1 and element bit M-1 is 1, out_data=0; otherwise out_data equals the element unchanged.
REQ-030 There is no width growth and no saturation.
REQ-031 clr=1 in any state SHALL, on the next edge: enter IDLE, drop out_valid, clear the counters and suppress frame_done.
REQ-032 clr SHALL take priority over a simultaneous capture or transfer.
REQ-033 out_ready=1 while out_valid=0 SHALL have no effect.
REQ-034 X=1 or Y=1 SHALL be supported; X=Y=1 produces a single beat with out_last=1.

Reset
REQ-035 rst=0 SHALL asynchronously force: state=IDLE, counters=0, out_valid=0, frame_done=0, in_ready=1.
REQ-036 The frame register need not be reset; out_data is don't-care while out_valid=0.
REQ-037 Reset asserted mid-STREAM SHALL discard the frame; no frame_done pulse follows.
REQ-038 Release of rst SHALL be synchronous to clk; the first capture can occur on the first edge after release.

Structure
REQ-039 The state encoding (IDLE=0, STREAM=1) and the counter-width function SHALL live in the shared package mtrx_mul_pkg.
REQ-040 The nested x/y counter with wrap and last detection SHALL be one sub-module, drain_index_cnt, reused by later stages.
REQ-041 Element selection SHALL be an indexed part-select from the frame register, with no other sub-modules.

Verification (bench parameters X=2, Y=3, M=5)
REQ-042 Basic frame: Data elements e=0..5 set to values 1..6, out_ready held at 1 -> beats (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4, (1,1)=5, (1,2)=6; out_last on the 6th beat; frame_done one cycle later; first beat one cycle after capture.
REQ-043 Backpressure: out_ready=0 for 3 cycles on beat (0,1) -> the beat holds value 2 stable for 4 cycles, with no skipped or duplicated beats.
REQ-044 Input ignored: in_valid pulsed with new Data mid-stream -> in_ready=0 and the stream continues with the original values.
REQ-045 ReLU: RELU=1 with element (1,0)=5'b10011 -> out_data=0; with RELU=0 -> out_data=5'b10011.
REQ-046 Abort: clr on beat (1,1), then rst=0 mid-stream in a second frame -> out_valid=0 the next cycle, no frame_done, in_ready=1, and a new frame restarts at (0,0).
